// File: rtl/reg_access_pkg.sv
// Shared constants and types for the register access arbiter: register map,
// FSM state encoding and reset values.
package reg_access_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam int unsigned ADDR_ID      = 0;
  localparam int unsigned ADDR_CTRL    = 1;
  localparam int unsigned ADDR_SCRATCH = 2;
  localparam int unsigned ADDR_STATUS  = 3;
  localparam int unsigned ADDR_ACC_CNT = 4;

  localparam logic [7:0] CTRL_RST     = 8'h00;
  localparam logic [7:0] SCRATCH_RST  = 8'h00;
  localparam logic [7:0] ACC_CNT_RST  = 8'h00;
  localparam logic       ERR_RST      = 1'b0;
  localparam logic       LAST_GNT_RST = 1'b1;

  localparam logic [7:0] ID_EXPECTED  = 8'hA7;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant selection. Purely combinational; the caller owns
// the last-grant register and only consumes gnt when a request is present.
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt
);

  always_comb begin
    if (req0 && req1) begin
      gnt = ~last_gnt;
    end else begin
      gnt = req1;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Two-port REQ/ACK arbiter onto a small control/status register space with
// fixed two-clock latency from request sampling to ACK.
module reg_access_arbiter
  import reg_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic [7:0]        id_in,
  output logic [DATA_W-1:0] ctrl_out,
  output logic              busy
);

  state_e state_q, state_d;

  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic              err_q, err_d;
  logic              last_gnt_q, last_gnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;

  logic              gnt;
  logic              any_req;
  logic [DATA_W-1:0] rd_val;
  logic              err_hit;
  logic              wr_ctrl;
  logic              wr_scratch;
  logic              clr_err;

  assign any_req = req0 | req1;

  rr_arbiter_2 u_rr_arbiter_2 (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Register-map decode of the latched transaction.
  always_comb begin
    rd_val     = '0;
    err_hit    = 1'b0;
    wr_ctrl    = 1'b0;
    wr_scratch = 1'b0;
    clr_err    = 1'b0;
    case (addr_q)
      ADDR_W'(ADDR_ID): begin
        rd_val  = DATA_W'(id_in);
        err_hit = we_q;
      end
      ADDR_W'(ADDR_CTRL): begin
        rd_val  = ctrl_q;
        wr_ctrl = we_q;
      end
      ADDR_W'(ADDR_SCRATCH): begin
        rd_val     = scratch_q;
        wr_scratch = we_q;
      end
      ADDR_W'(ADDR_STATUS): begin
        rd_val  = DATA_W'({last_gnt_q, err_q});
        clr_err = we_q & wdata_q[0];
      end
      ADDR_W'(ADDR_ACC_CNT): begin
        rd_val  = DATA_W'(acc_q);
        err_hit = we_q;
      end
      default: begin
        rd_val  = '0;
        err_hit = 1'b1;
      end
    endcase
  end

  // Datapath next state
  always_comb begin
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    err_d      = err_q;
    last_gnt_d = last_gnt_q;
    acc_d      = acc_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    if (state_q == StIdle && any_req) begin
      win_d   = gnt;
      we_d    = gnt ? we1 : we0;
      addr_d  = gnt ? addr1 : addr0;
      wdata_d = gnt ? wdata1 : wdata0;
    end

    if (state_q == StAccess) begin
      if (wr_ctrl) ctrl_d = wdata_q;
      if (wr_scratch) scratch_d = wdata_q;
      if (err_hit) begin
        err_d = 1'b1;
      end else if (clr_err) begin
        err_d = 1'b0;
      end
      acc_d      = acc_q + 8'd1;
      last_gnt_d = win_q;
      if (!we_q) begin
        if (win_q) begin
          rdata1_d = rd_val;
        end else begin
          rdata0_d = rd_val;
        end
      end
      ack0_d = ~win_q;
      ack1_d = win_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= DATA_W'(CTRL_RST);
      scratch_q  <= DATA_W'(SCRATCH_RST);
      err_q      <= ERR_RST;
      last_gnt_q <= LAST_GNT_RST;
      acc_q      <= ACC_CNT_RST;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      scratch_q  <= scratch_d;
      err_q      <= err_d;
      last_gnt_q <= last_gnt_d;
      acc_q      <= acc_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Randomized bench for reg_access_arbiter against a register-map level model.
module tb_reg_access_arbiter;
  import reg_access_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] id_in;
  logic [7:0] ctrl_out;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [7:0] m_ctrl, m_scratch, m_acc;
  logic       m_err;
  int         m_last;

  reg_access_arbiter #(
    .ADDR_W (4),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .id_in    (id_in),
    .ctrl_out (ctrl_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl    = 8'h00;
    m_scratch = 8'h00;
    m_acc     = 8'h00;
    m_err     = 1'b0;
    m_last    = 1;
  endtask

  // Applies one completed transaction; returns the value a read must see.
  function automatic logic [7:0] model_access(input int port, input logic we,
                                              input logic [3:0] a, input logic [7:0] d);
    logic [7:0] rd;
    rd = 8'h00;
    case (a)
      4'h0: begin rd = ID_EXPECTED; if (we) m_err = 1'b1; end
      4'h1: begin rd = m_ctrl; if (we) m_ctrl = d; end
      4'h2: begin rd = m_scratch; if (we) m_scratch = d; end
      4'h3: begin rd = {6'b0, m_last[0], m_err}; if (we && d[0]) m_err = 1'b0; end
      4'h4: begin rd = m_acc; if (we) m_err = 1'b1; end
      default: m_err = 1'b1;
    endcase
    m_acc  = m_acc + 8'd1;
    m_last = port;
    return rd;
  endfunction

  task automatic drive(input int port, input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    if (port == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Single-port transaction from an idle FSM; checks latency, data and CTRL.
  task automatic do_txn(input int port, input logic we, input logic [3:0] a,
                        input logic [7:0] d);
    logic [7:0] exp;
    int  n;
    bit  got;
    @(negedge clk);
    drive(port, 1'b1, we, a, d);
    n = 0;
    got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      check_eq("other_ack", (port == 0) ? ack1 : ack0, 0);
      if ((port == 0) ? ack0 : ack1) got = 1;
    end
    check_eq("ack_latency", n, 2);
    drive(port, 1'b0, 1'b0, 4'h0, 8'h00);
    if (got) begin
      exp = model_access(port, we, a, d);
      if (!we) check_eq("rdata", (port == 0) ? rdata0 : rdata1, exp);
      check_eq("ctrl_out", ctrl_out, m_ctrl);
      check_eq("busy_at_ack", busy, 1);
    end
  endtask

  // Both ports request together; each drops REQ once served.
  task automatic do_pair(input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                         input logic w1, input logic [3:0] a1, input logic [7:0] d1);
    int served;
    int n;
    int p;
    logic [7:0] exp;
    @(negedge clk);
    drive(0, 1'b1, w0, a0, d0);
    drive(1, 1'b1, w1, a1, d1);
    served = 0;
    n = 0;
    while (served < 2 && n < 16) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) begin
        check_eq("pair_one_ack", ack0 & ack1, 0);
        p = ack1 ? 1 : 0;
        check_eq("pair_gnt", p, 1 - m_last);
        if (p == 0) exp = model_access(0, w0, a0, d0);
        else        exp = model_access(1, w1, a1, d1);
        if (!((p == 0) ? w0 : w1)) check_eq("pair_rdata", (p == 0) ? rdata0 : rdata1, exp);
        drive(p, 1'b0, 1'b0, 4'h0, 8'h00);
        served++;
      end
    end
    check_eq("pair_served", served, 2);
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int n;
    logic [7:0] exp;
    logic       w;
    logic [3:0] a;

    rst_n = 1'b0;
    id_in = ID_EXPECTED;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ack0", ack0, 0);
    check_eq("rst_ack1", ack1, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ctrl", ctrl_out, 8'h00);
    check_eq("rst_rdata0", rdata0, 8'h00);
    check_eq("rst_rdata1", rdata1, 8'h00);

    // ID read, then its side effects
    do_txn(0, 1'b0, 4'h0, 8'h00);
    check_eq("id_read", rdata0, 8'hA7);
    do_txn(0, 1'b0, 4'h4, 8'h00);
    check_eq("acc_after_one", rdata0, 8'h01);
    do_txn(0, 1'b0, 4'h3, 8'h00);
    check_eq("status_err0", rdata0[0], 0);

    // Port 1 CTRL write and readback
    do_txn(1, 1'b1, 4'h1, 8'h5A);
    check_eq("ctrl_written", ctrl_out, 8'h5A);
    do_txn(1, 1'b0, 4'h1, 8'h00);
    check_eq("ctrl_readback", rdata1, 8'h5A);

    // Tie: both hold REQ, grants must alternate 0,1,0,1
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'h1, 8'h00);
    drive(1, 1'b1, 1'b0, 4'h2, 8'h00);
    for (int k = 0; k < 4; k++) begin
      got = -1;
      n = 0;
      while (got < 0 && n < 10) begin
        @(negedge clk);
        n++;
        if (ack0) got = 0;
        else if (ack1) got = 1;
      end
      check_eq("tie_gnt", got, k % 2);
      if (got >= 0) begin
        exp = model_access(got, 1'b0, (got == 0) ? 4'h1 : 4'h2, 8'h00);
        check_eq("tie_rdata", (got == 0) ? rdata0 : rdata1, exp);
      end
    end
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);

    // Illegal ID write, STATUS error bit, W1C clear
    do_txn(0, 1'b1, 4'h0, 8'hFF);
    do_txn(0, 1'b0, 4'h0, 8'h00);
    check_eq("id_unchanged", rdata0, 8'hA7);
    do_txn(0, 1'b0, 4'h3, 8'h00);
    check_eq("status_err1", rdata0[0], 1);
    do_txn(1, 1'b1, 4'h3, 8'h01);
    do_txn(1, 1'b0, 4'h3, 8'h00);
    check_eq("status_cleared", rdata1[0], 0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_pair($urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)), 8'($urandom),
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)), 8'($urandom));
      end else begin
        w = ($urandom_range(0, 2) == 0);
        a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
        do_txn(int'($urandom_range(0, 1)), w, a, 8'($urandom));
      end
    end

    // Counter wrap, then out-of-map access
    while (m_acc != 8'h00) do_txn(0, 1'b0, 4'h2, 8'h00);
    do_txn(1, 1'b0, 4'h4, 8'h00);
    check_eq("acc_wrapped", rdata1, 8'h00);
    do_txn(0, 1'b0, 4'h9, 8'h00);
    check_eq("unmapped_read", rdata0, 8'h00);
    do_txn(0, 1'b0, 4'h3, 8'h00);
    check_eq("unmapped_err", rdata0[0], 1);

    // Reset while a SCRATCH write is in ACCESS
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'h2, 8'h33);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_ack0", ack0, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ctrl", ctrl_out, 8'h00);
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(0, 1'b0, 4'h2, 8'h00);
    check_eq("scratch_after_rst", rdata0, 8'h00);
    do_txn(0, 1'b1, 4'h2, 8'h33);
    do_txn(1, 1'b0, 4'h2, 8'h00);
    check_eq("scratch_reissued", rdata1, 8'h33);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Arbitrates two requesters (host port 0, debug/CPU port 1) onto the chip's small control/status register space. The space holds the read-only ID value from the ID register block, plus control, scratch, status and access-count registers. It sits beside the ID register at the top level, and its CTRL register drives datapath configuration. Each transaction uses a REQ/ACK handshake with round-robin fairness and fixed latency.

## Interface
- ADDR_W, default 4: register address width.
- DATA_W, default 8: register data width; must equal the ID width (8).
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0 / REQ1  in  1  access request, ports 0/1.
- WE0 / WE1  in  1  1 = write, 0 = read; held stable while REQ high.
- ADDR0 / ADDR1  in  ADDR_W  register address; held stable while REQ high.
- WDATA0 / WDATA1  in  DATA_W  write data; held stable while REQ high.
- ACK0 / ACK1  out  1  one-cycle completion pulse; reset 0.
- RDATA0 / RDATA1  out  DATA_W  read data, valid with ACK and held until the next ACK on that port; reset 0x00.
- ID_IN  in  8  constant ID value (0xA7 from the ID register block).
- CTRL_OUT  out  DATA_W  CTRL register contents; reset 0x00.
- BUSY  out  1  high in every state other than IDLE; reset 0.

## Operation
- Register map:
  - 0x0 ID: RO, reads ID_IN.
  - 0x1 CTRL: RW, reset 0x00.
  - 0x2 SCRATCH: RW, reset 0x00.
  - 0x3 STATUS: {6'b0, LAST_GNT, ERR}. Writing 1 to bit0 clears ERR; other bits ignored.
  - 0x4 ACC_CNT: RO, 8-bit.
  - 0x5–0xF: read 0x00.
- Error cases set ERR (sticky): a write to ID or ACC_CNT (write is ignored), and any access to 0x5–0xF.
- FSM states and transitions:
  - IDLE: when any REQ is high, select a winner and latch its WE, ADDR and WDATA, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: perform the register write or read, register RDATA for the winner, update ERR/ACC_CNT/LAST_GNT, then go to DONE.
  - DONE: ACK of the winner is high, then go to IDLE unconditionally.
- Arbitration:
  - If only one REQ is high, that port wins.
  - If both are high, the port that is not LAST_GNT wins.
  - After reset LAST_GNT=1, so port 0 wins the first tie.
- ACC_CNT increments once per completed transaction, including erroring transactions and the W1C write. It wraps 0xFF→0x00.
- LAST_GNT updates to the winner in ACCESS.
- A REQ still high in the IDLE cycle after ACK is a new request. Requesters wanting a single access drop REQ in the cycle after ACK.
- The losing requester keeps REQ high and is served next; no request is lost.
- Reset mid-transaction: the FSM goes to IDLE immediately, ACK drops, and all registers return to reset values. The pending transaction is discarded and the requester must reissue.

## Timing
- REQ sampled high at edge E (in IDLE): state is ACCESS after E. The write commits at E+1. ACK and RDATA are valid in the cycle after E+1 (DONE).
- Latency: 2 clocks from sampling edge to ACK. Minimum transaction period is 3 clocks.
- CTRL_OUT reflects a write from the edge E+1.
- A read of STATUS returns the value before that transaction's own update.
- A read of ACC_CNT returns the pre-increment value.
- No combinational path from REQ/ADDR to any output; all outputs are registered.

## Structure
- Package reg_access_pkg holds:
  - address constants ADDR_ID, ADDR_CTRL, ADDR_SCRATCH, ADDR_STATUS, ADDR_ACC_CNT;
  - the state encoding IDLE/ACCESS/DONE;
  - reset values, and ID_EXPECTED = 8'hA7 for the bench.
- Sub-module rr_arbiter_2: inputs REQ0, REQ1 and LAST_GNT; output GNT index. Purely combinational; the LAST_GNT register lives in the parent.

## Test plan
- Reset, then port 0 reads 0x0 → ACK0 two clocks after sampling, RDATA0=0xA7, ACC_CNT=0x01, ERR=0.
- Port 1 writes 0x5A to 0x1, then reads it back → CTRL_OUT=0x5A from the write's commit edge, RDATA1=0x5A, port 0 never ACKed.
- REQ0 and REQ1 rise together and both hold REQ high, each reading a different register → grants alternate 0,1,0,1. Each ACK carries the correct RDATA, and no port gets two consecutive grants while the other is requesting.
- Write 0xFF to 0x0, then read 0x3 → ID still reads 0xA7, STATUS bit0=1. Then write 0x01 to 0x3 → ERR=0 on the next STATUS read.
- Perform 256 accesses → ACC_CNT wraps to 0x00. Then an access to 0x9 → RDATA=0x00, ERR=1.
- Assert RST_N low during ACCESS of a write of 0x33 to 0x2 → no ACK, BUSY=0. SCRATCH reads 0x00 after reset, and a reissued write then succeeds.
